// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: RV32I major opcodes, the
// redirect FSM state encoding and the opcode -> operand-use decode.
package issue_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } opnd_use_t;

  // Which register fields the instruction actually reads/writes.
  // FENCE, SYSTEM and unknown opcodes touch no registers.
  function automatic opnd_use_t opnd_use(input logic [6:0] opc);
    opnd_use_t u;
    u = '0;
    case (opc)
      OPC_OP:                          begin u.rs1 = 1'b1; u.rs2 = 1'b1; u.rd = 1'b1; end
      OPC_STORE, OPC_BRANCH:           begin u.rs1 = 1'b1; u.rs2 = 1'b1; end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:  begin u.rs1 = 1'b1; u.rd = 1'b1; end
      OPC_JAL, OPC_LUI, OPC_AUIPC:     u.rd = 1'b1;
      default:                         u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Register scoreboard: one busy bit per architectural register (x0 is
// hard-wired to not busy). Ports:
//   clk, rst          clock, synchronous active-high reset
//   set_en/set_idx    mark a register as pending writeback
//   clr_en/clr_idx    retire a pending writeback (clear wins over set)
//   rd_idx_*/busy_*   three combinational lookups (rs1, rs2, rd)
//   clr_idle          clear requested on a register that is not busy
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rd_idx_a,
  input  logic [4:0] rd_idx_b,
  input  logic [4:0] rd_idx_c,
  output logic       busy_a,
  output logic       busy_b,
  output logic       busy_c,
  output logic       clr_idle
);

  logic [31:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // bit 0 stays a constant zero flop; synthesis removes it
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_a   = busy_q[rd_idx_a];
  assign busy_b   = busy_q[rd_idx_b];
  assign busy_c   = busy_q[rd_idx_c];
  assign clr_idle = clr_en & ~busy_q[clr_idx];

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller between decode and execute. Blocks issue on RAW/WAW
// hazards against the scoreboard, caps in-flight instructions, and turns a
// taken branch into a registered FLUSH/PC_SET pulse followed by a refill
// window in which issue is masked.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   D_VALID/D_OPCODE/D_REG_*       decoded instruction
//   EX_READY                       execute accepts this cycle
//   W_VALID/W_REG_WE/W_REG_D       retirement
//   BR_REQ/BR_PC                   taken branch/jump redirect
//   STALL/ISSUE                    combinational decode handshake
//   FLUSH/PC_SET/PC_NEW            registered redirect pulse
//   INFLIGHT                       issued-but-not-retired count
//   ERR                            sticky protocol error
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT  = 4,
  parameter int REFILL_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        D_VALID,
  input  logic [6:0]  D_OPCODE,
  input  logic [4:0]  D_REG_D,
  input  logic [4:0]  D_REG_S1,
  input  logic [4:0]  D_REG_S2,
  input  logic        EX_READY,
  input  logic        W_VALID,
  input  logic        W_REG_WE,
  input  logic [4:0]  W_REG_D,
  input  logic        BR_REQ,
  input  logic [31:0] BR_PC,
  output logic        STALL,
  output logic        ISSUE,
  output logic        FLUSH,
  output logic        PC_SET,
  output logic [31:0] PC_NEW,
  output logic [3:0]  INFLIGHT,
  output logic        ERR
);

  localparam int CW = $clog2(REFILL_CYCLES + 1);

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]   inflight_q, inflight_d;
  logic         err_q, err_d;
  logic         flush_q, flush_d;
  logic [31:0]  pc_new_q, pc_new_d;

  opnd_use_t use_w;
  logic      busy_rs1, busy_rs2, busy_rd, clr_idle;
  logic      hazard, issue, stall, retire_clr;

  assign use_w      = opnd_use(D_OPCODE);
  assign retire_clr = W_VALID & W_REG_WE & (W_REG_D != 5'd0);

  issue_scoreboard u_sb (
    .clk      (CLK),
    .rst      (RST),
    .set_en   (issue & use_w.rd),
    .set_idx  (D_REG_D),
    .clr_en   (retire_clr),
    .clr_idx  (W_REG_D),
    .rd_idx_a (D_REG_S1),
    .rd_idx_b (D_REG_S2),
    .rd_idx_c (D_REG_D),
    .busy_a   (busy_rs1),
    .busy_b   (busy_rs2),
    .busy_c   (busy_rd),
    .clr_idle (clr_idle)
  );

  // x0 reads as never busy in the scoreboard, so no explicit !=0 terms needed
  assign hazard = (use_w.rs1 & busy_rs1) | (use_w.rs2 & busy_rs2) | (use_w.rd & busy_rd);

  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    if (!RST && state_q == ST_RUN) begin
      issue = D_VALID & ~hazard & EX_READY & (inflight_q < 4'(MAX_INFLIGHT)) & ~BR_REQ;
      stall = D_VALID & ~issue & ~BR_REQ;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    flush_d    = BR_REQ;
    pc_new_d   = BR_REQ ? BR_PC : pc_new_q;

    // a redirect always (re)starts the refill window, even inside one
    if (BR_REQ) begin
      state_d = ST_REFILL;
      cnt_d   = CW'(REFILL_CYCLES);
    end else if (state_q == ST_REFILL) begin
      if (cnt_q == CW'(1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    case ({issue, W_VALID})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   if (inflight_q != 4'd0) inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase

    if ((W_VALID && inflight_q == 4'd0) || clr_idle) err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      flush_q    <= 1'b0;
      pc_new_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      flush_q    <= flush_d;
      pc_new_q   <= pc_new_d;
    end
  end

  assign ISSUE    = issue;
  assign STALL    = stall;
  assign FLUSH    = flush_q;
  assign PC_SET   = flush_q;
  assign PC_NEW   = pc_new_q;
  assign INFLIGHT = inflight_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] FNC  = 7'b0001111;

  logic        clk = 1'b0;
  logic        rst, d_valid, ex_ready, w_valid, w_we, br_req;
  logic [6:0]  d_opc;
  logic [4:0]  d_rd, d_rs1, d_rs2, w_rd;
  logic [31:0] br_pc;
  logic        stall, issue, flush, pc_set, err;
  logic [31:0] pc_new;
  logic [3:0]  inflight;

  always #5 clk = ~clk;

  issue_ctrl #(.MAX_INFLIGHT(4), .REFILL_CYCLES(2)) dut (
    .CLK(clk), .RST(rst), .D_VALID(d_valid), .D_OPCODE(d_opc), .D_REG_D(d_rd),
    .D_REG_S1(d_rs1), .D_REG_S2(d_rs2), .EX_READY(ex_ready), .W_VALID(w_valid),
    .W_REG_WE(w_we), .W_REG_D(w_rd), .BR_REQ(br_req), .BR_PC(br_pc),
    .STALL(stall), .ISSUE(issue), .FLUSH(flush), .PC_SET(pc_set), .PC_NEW(pc_new),
    .INFLIGHT(inflight), .ERR(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, dv; logic [6:0] opc; logic [4:0] rd, rs1, rs2;
    logic exr, wv, wwe; logic [4:0] wrd; logic br; logic [31:0] bpc;
    logic e_iss, e_stl, e_fl; logic [31:0] e_pc; logic [3:0] e_inf; logic e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, dv, input logic [6:0] opc,
                              input logic [4:0] rd, rs1, rs2, input logic exr, wv, wwe,
                              input logic [4:0] wrd, input logic br, input logic [31:0] bpc,
                              input logic iss, stl, fl, input logic [31:0] pc,
                              input logic [3:0] inf, input logic er);
    vec_t v;
    v.rst = r; v.dv = dv; v.opc = opc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.exr = exr; v.wv = wv; v.wwe = wwe; v.wrd = wrd; v.br = br; v.bpc = bpc;
    v.e_iss = iss; v.e_stl = stl; v.e_fl = fl; v.e_pc = pc; v.e_inf = inf; v.e_err = er;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; d_valid = v.dv; d_opc = v.opc; d_rd = v.rd; d_rs1 = v.rs1; d_rs2 = v.rs2;
    ex_ready = v.exr; w_valid = v.wv; w_we = v.wwe; w_rd = v.wrd; br_req = v.br; br_pc = v.bpc;
  endtask

  vec_t tbl[$];

  // ---------------- reference model ----------------
  bit          mb[32];
  int          minf, mleft;
  bit          merr, mfl;
  logic [31:0] mpc;

  task automatic uses(input logic [6:0] opc, output bit u1, u2, ud);
    u1 = 0; u2 = 0; ud = 0;
    case (opc)
      7'b0110011:                         begin u1 = 1; u2 = 1; ud = 1; end
      7'b0100011, 7'b1100011:             begin u1 = 1; u2 = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin u1 = 1; ud = 1; end
      7'b1101111, 7'b0110111, 7'b0010111: ud = 1;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    foreach (mb[i]) mb[i] = 0;
    minf = 0; mleft = 0; merr = 0; mfl = 0; mpc = 0;
  endtask

  task automatic model_comb(output bit e_iss, e_stl);
    bit u1, u2, ud, hz;
    uses(d_opc, u1, u2, ud);
    hz = (u1 && d_rs1 != 0 && mb[d_rs1]) || (u2 && d_rs2 != 0 && mb[d_rs2]) ||
         (ud && d_rd != 0 && mb[d_rd]);
    e_iss = !rst && mleft == 0 && d_valid && !hz && ex_ready && minf < 4 && !br_req;
    e_stl = !rst && mleft == 0 && d_valid && !e_iss && !br_req;
  endtask

  task automatic model_step(input bit e_iss);
    bit u1, u2, ud;
    if (rst) begin model_reset(); return; end
    uses(d_opc, u1, u2, ud);
    mfl = br_req;
    if (br_req) mpc = br_pc;
    if (br_req) mleft = 2; else if (mleft > 0) mleft--;
    if (w_valid && minf == 0) merr = 1;
    if (w_valid && w_we && w_rd != 0 && !mb[w_rd]) merr = 1;
    if (e_iss && ud && d_rd != 0) mb[d_rd] = 1;
    if (w_valid && w_we && w_rd != 0) mb[w_rd] = 0;
    minf = minf + (e_iss ? 1 : 0) - (w_valid ? 1 : 0);
    if (minf < 0) minf = 0;
  endtask

  initial begin
    // rst dv opc  rd rs1 rs2 exr wv we wrd br bpc    | iss stl fl pc      inf err
    tbl.push_back(mk(1,0,7'h0,0,0,0, 0,0,0,0, 0,32'h0,   0,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,1,ADD ,3,1,2, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,1,ADDI,4,3,0, 1,0,0,0, 0,32'h0,   0,1,0,32'h0,  1,0));
    tbl.push_back(mk(0,1,ADDI,4,3,0, 1,1,1,3, 0,32'h0,   0,1,0,32'h0,  1,0));
    tbl.push_back(mk(0,1,ADDI,4,3,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,1,LUI ,0,0,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  1,0));
    tbl.push_back(mk(0,1,ADDI,1,0,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  2,0));
    tbl.push_back(mk(0,1,SW  ,0,2,1, 1,0,0,0, 0,32'h0,   0,1,0,32'h0,  3,0));
    tbl.push_back(mk(0,1,LUI ,0,0,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  3,0));
    tbl.push_back(mk(0,1,ADD ,5,0,0, 1,0,0,0, 0,32'h0,   0,1,0,32'h0,  4,0));
    tbl.push_back(mk(0,1,ADD ,5,0,0, 1,1,1,4, 0,32'h0,   0,1,0,32'h0,  4,0));
    tbl.push_back(mk(0,1,ADD ,5,0,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  3,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,1,1,1, 0,32'h0,   0,0,0,32'h0,  4,0));
    tbl.push_back(mk(0,1,ADD ,6,0,0, 1,0,0,0, 1,32'h100, 0,0,0,32'h0,  3,0));
    tbl.push_back(mk(0,1,ADD ,6,0,0, 1,0,0,0, 0,32'h0,   0,0,1,32'h100,3,0));
    tbl.push_back(mk(0,1,ADD ,6,0,0, 1,0,0,0, 0,32'h0,   0,0,0,32'h0,  3,0));
    tbl.push_back(mk(0,1,ADD ,6,0,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  3,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,1,0,0, 0,32'h0,   0,0,0,32'h0,  4,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,1,1,5, 0,32'h0,   0,0,0,32'h0,  3,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,1,1,6, 0,32'h0,   0,0,0,32'h0,  2,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,1,0,0, 0,32'h0,   0,0,0,32'h0,  1,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,1,0,0, 0,32'h0,   0,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,0,0,0, 0,32'h0,   0,0,0,32'h0,  0,1));
    tbl.push_back(mk(1,0,ADD ,0,0,0, 1,0,0,0, 0,32'h0,   0,0,0,32'h0,  0,1));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,0,0,0, 0,32'h0,   0,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,1,ADD ,7,0,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,1,1,8, 0,32'h0,   0,0,0,32'h0,  1,0));
    tbl.push_back(mk(0,0,ADD ,0,0,0, 1,0,0,0, 0,32'h0,   0,0,0,32'h0,  0,1));
    tbl.push_back(mk(1,0,ADD ,0,0,0, 1,0,0,0, 0,32'h0,   0,0,0,32'h0,  0,1));
    tbl.push_back(mk(0,1,ADD ,9,0,0, 1,0,0,0, 1,32'h200, 0,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,1,ADD ,9,0,0, 1,0,0,0, 1,32'h300, 0,0,1,32'h200,0,0));
    tbl.push_back(mk(0,1,ADD ,9,0,0, 1,0,0,0, 0,32'h0,   0,0,1,32'h300,0,0));
    tbl.push_back(mk(0,1,ADD ,9,0,0, 1,0,0,0, 0,32'h0,   0,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,1,ADD ,9,0,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  0,0));
    tbl.push_back(mk(0,1,ADD ,10,0,0,0,0,0,0, 0,32'h0,   0,1,0,32'h0,  1,0));
    tbl.push_back(mk(0,1,FNC ,9,9,9, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  1,0));
    tbl.push_back(mk(0,1,BEQ ,9,9,0, 1,0,0,0, 0,32'h0,   0,1,0,32'h0,  2,0));
    tbl.push_back(mk(1,0,BEQ ,9,9,0, 1,0,0,0, 0,32'h0,   0,0,0,32'h0,  2,0));
    tbl.push_back(mk(0,1,BEQ ,9,9,0, 1,0,0,0, 0,32'h0,   1,0,0,32'h0,  0,0));

    drive(mk(1,0,7'h0,0,0,0,0,0,0,0,0,32'h0, 0,0,0,32'h0,0,0));
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d.issue", i), issue, tbl[i].e_iss);
      chk($sformatf("v%0d.stall", i), stall, tbl[i].e_stl);
      chk($sformatf("v%0d.flush", i), flush, tbl[i].e_fl);
      chk($sformatf("v%0d.pc_set", i), pc_set, tbl[i].e_fl);
      if (i == 0 || tbl[i].e_fl) chk($sformatf("v%0d.pc_new", i), pc_new, tbl[i].e_pc);
      chk($sformatf("v%0d.inflight", i), inflight, tbl[i].e_inf);
      chk($sformatf("v%0d.err", i), err, tbl[i].e_err);
      @(posedge clk);
      #1;
    end

    // randomized run against the reference model
    begin
      logic [6:0] ops[12];
      int         bq[$];
      bit         e_iss, e_stl;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
              7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011, 7'b1111111};
      rst = 1; w_valid = 0; br_req = 0; d_valid = 0;
      @(posedge clk);
      #1;
      model_reset();
      for (int c = 0; c < 4000; c++) begin
        rst      = ($urandom_range(0, 199) == 0);
        d_valid  = ($urandom_range(0, 9) < 7);
        d_opc    = ops[$urandom_range(0, 11)];
        d_rd     = 5'($urandom_range(0, 7));
        d_rs1    = 5'($urandom_range(0, 7));
        d_rs2    = 5'($urandom_range(0, 7));
        ex_ready = ($urandom_range(0, 9) < 8);
        w_valid = 0; w_we = 1'($urandom_range(0, 1)); w_rd = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 99) < 3) begin
          w_valid = 1; w_we = 1;
        end else if (minf > 0 && $urandom_range(0, 9) < 4) begin
          w_valid = 1;
          bq.delete();
          for (int r = 1; r < 8; r++) if (mb[r]) bq.push_back(r);
          if (bq.size() > 0 && $urandom_range(0, 3) != 0) begin
            w_we = 1; w_rd = 5'(bq[$urandom_range(0, bq.size() - 1)]);
          end else begin
            w_we = 0;
          end
        end
        br_req = ($urandom_range(0, 19) == 0);
        br_pc  = $urandom;
        model_comb(e_iss, e_stl);
        @(negedge clk);
        chk("rnd.issue", issue, e_iss);
        chk("rnd.stall", stall, e_stl);
        chk("rnd.flush", flush, mfl);
        chk("rnd.pc_set", pc_set, mfl);
        if (mfl) chk("rnd.pc_new", pc_new, mpc);
        chk("rnd.inflight", inflight, 32'(minf));
        chk("rnd.err", err, merr);
        @(posedge clk);
        model_step(e_iss);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
